// File: rtl/axis_byte_unpacker_pkg.sv
// ============================================================================
// Module   : axis_unpack_pkg
// Purpose  : Shared constants, state encoding and lane-width helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package axis_unpack_pkg;

  localparam int BYTE_W = 8;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  typedef enum logic [0:0] {
    EMPTY = ST_EMPTY,
    DRAIN = ST_DRAIN
  } state_e;

  function automatic int lane_idx_w(input int keep_w);
    return (keep_w > 1) ? $clog2(keep_w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_byte_unpacker_if.sv
// ============================================================================
// Module   : axis_byte_unpacker_if
// Purpose  : Generic AXI4-Stream bundle with master/slave views.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface axis_byte_unpacker_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

`default_nettype wire

// File: rtl/axis_byte_unpacker_lane_sel.sv
// ============================================================================
// Module   : axis_unpack_lane_sel
// Purpose  : Picks the next lane to emit from the remaining-lane mask.
//            Macro AXIS_UNPACK_SPARSE_KEEP_EN selects skip-over-zero-keep mode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axis_unpack_lane_sel
  import axis_unpack_pkg::*;
#(
  parameter int KEEP_W = 8,
  parameter int LANE_W = 3
) (
  input  wire logic [KEEP_W-1:0] rem_mask,
  input  wire logic [LANE_W-1:0] ptr,
  output logic      [LANE_W-1:0] next_lane,
  output logic                   is_final
);

  // rem_mask holds only lanes strictly after the current one
  assign is_final = (rem_mask == '0);

`ifdef AXIS_UNPACK_SPARSE_KEEP_EN
  always_comb begin
    next_lane = ptr;
    for (int i = KEEP_W - 1; i >= 0; i--) begin
      if (rem_mask[i]) next_lane = LANE_W'(i);
    end
  end
`else
  assign next_lane = ptr + LANE_W'(1);
`endif

endmodule

`default_nettype wire

// File: rtl/axis_byte_unpacker.sv
// ============================================================================
// Module   : axis_byte_unpacker
// Purpose  : Wide AXI4-Stream beat in, one byte per cycle out, with frame length.
//            Optional macro: AXIS_UNPACK_SPARSE_KEEP_EN (emit only keep=1 lanes).
// Revision : 1.0
// ============================================================================
`default_nettype none

module axis_byte_unpacker
  import axis_unpack_pkg::*;
#(
  parameter int S_DATA_WIDTH = 64,
  parameter int S_KEEP_WIDTH = S_DATA_WIDTH / 8,
  parameter int ID_ENABLE    = 0,
  parameter int ID_WIDTH     = 8,
  parameter int DEST_ENABLE  = 0,
  parameter int DEST_WIDTH   = 8,
  parameter int USER_ENABLE  = 1,
  parameter int USER_WIDTH   = 1,
  parameter int LEN_WIDTH    = 16
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  axis_byte_unpacker_if.slave       s_axis,
  axis_byte_unpacker_if.master      m_axis,
  output logic      [LEN_WIDTH-1:0] frame_len,
  output logic                      frame_len_valid
);

  localparam int LANE_W = lane_idx_w(S_KEEP_WIDTH);

  state_e                  state_q, state_d;
  logic [S_DATA_WIDTH-1:0] data_q, data_d;
  logic [S_KEEP_WIDTH-1:0] mask_q, mask_d;
  logic [LANE_W-1:0]       ptr_q, ptr_d;
  logic                    last_q, last_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [DEST_WIDTH-1:0]   dest_q, dest_d;
  logic [USER_WIDTH-1:0]   user_q, user_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic                    len_vld_q, len_vld_d;

  logic [LANE_W-1:0]       next_lane;
  logic                    is_final;
  logic [S_KEEP_WIDTH-1:0] keep_eff;
  logic [S_KEEP_WIDTH-1:0] load_mask;
  logic [LANE_W-1:0]       first_lane;
  logic                    load_drop;
  logic                    m_valid;
  logic                    m_last;
  logic                    m_hs;
  logic                    s_ready;
  logic                    s_hs;
  logic [LEN_WIDTH-1:0]    cnt_inc;

  axis_unpack_lane_sel #(
    .KEEP_W (S_KEEP_WIDTH),
    .LANE_W (LANE_W)
  ) u_lane_sel (
    .rem_mask  (mask_q),
    .ptr       (ptr_q),
    .next_lane (next_lane),
    .is_final  (is_final)
  );

  // An empty-keep last beat still has to deliver tlast, so it is sent as lane 0.
  always_comb begin
    keep_eff   = s_axis.tkeep;
    if (s_axis.tkeep == '0) keep_eff[0] = 1'b1;
    load_drop  = (s_axis.tkeep == '0) && !s_axis.tlast;
    first_lane = '0;
`ifdef AXIS_UNPACK_SPARSE_KEEP_EN
    for (int i = S_KEEP_WIDTH - 1; i >= 0; i--) begin
      if (keep_eff[i]) first_lane = LANE_W'(i);
    end
    load_mask = keep_eff;
`else
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      load_mask[i] = |(keep_eff >> i);
    end
`endif
    load_mask[first_lane] = 1'b0;
  end

  assign m_valid = (state_q == DRAIN);
  assign m_last  = m_valid && last_q && is_final;
  assign m_hs    = m_valid && m_axis.tready;
  assign s_ready = (state_q == EMPTY) || (m_axis.tready && is_final);
  assign s_hs    = s_axis.tvalid && s_ready;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + LEN_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    mask_d    = mask_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    id_d      = id_q;
    dest_d    = dest_q;
    user_d    = user_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    len_vld_d = 1'b0;

    if (m_hs) begin
      if (is_final) begin
        state_d = EMPTY;
      end else begin
        ptr_d             = next_lane;
        mask_d[next_lane] = 1'b0;
      end
      if (m_last) begin
        len_d     = cnt_inc;
        len_vld_d = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d     = cnt_inc;
      end
    end

    // A load on the final-byte edge overrides the drain-to-empty transition.
    if (s_hs) begin
      if (load_drop) begin
        state_d = EMPTY;
      end else begin
        state_d = DRAIN;
        data_d  = s_axis.tdata;
        mask_d  = load_mask;
        ptr_d   = first_lane;
        last_d  = s_axis.tlast;
        id_d    = s_axis.tid;
        dest_d  = s_axis.tdest;
        user_d  = s_axis.tuser;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      data_q    <= '0;
      mask_q    <= '0;
      ptr_q     <= '0;
      last_q    <= 1'b0;
      id_q      <= '0;
      dest_q    <= '0;
      user_q    <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      len_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      id_q      <= id_d;
      dest_q    <= dest_d;
      user_q    <= user_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      len_vld_q <= len_vld_d;
    end
  end

  assign s_axis.tready   = s_ready;
  assign m_axis.tdata    = data_q[int'(ptr_q) * BYTE_W +: BYTE_W];
  assign m_axis.tkeep    = '1;
  assign m_axis.tvalid   = m_valid;
  assign m_axis.tlast    = m_last;
  assign m_axis.tid      = (ID_ENABLE != 0)   ? id_q   : '0;
  assign m_axis.tdest    = (DEST_ENABLE != 0) ? dest_q : '0;
  assign m_axis.tuser    = (USER_ENABLE != 0) ? user_q : '0;
  assign frame_len       = len_q;
  assign frame_len_valid = len_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_byte_unpacker.sv
// ============================================================================
// Module   : tb_axis_byte_unpacker
// Purpose  : Randomised self-checking bench with a byte-queue reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axis_byte_unpacker;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_byte_unpacker_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(8),
                          .DEST_WIDTH(8), .USER_WIDTH(1)) s_if ();
  axis_byte_unpacker_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .ID_WIDTH(8),
                          .DEST_WIDTH(8), .USER_WIDTH(1)) m_if ();

  logic [LW-1:0] frame_len;
  logic          frame_len_valid;

  axis_byte_unpacker #(
    .S_DATA_WIDTH (DW), .S_KEEP_WIDTH (KW),
    .ID_ENABLE (0), .ID_WIDTH (8), .DEST_ENABLE (0), .DEST_WIDTH (8),
    .USER_ENABLE (1), .USER_WIDTH (1), .LEN_WIDTH (LW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .frame_len       (frame_len),
    .frame_len_valid (frame_len_valid)
  );

  typedef struct packed { logic [7:0] d; logic l; logic u; } byte_t;

  byte_t exp_q[$];
  byte_t log_q[$];
  int    log_cyc[$];
  byte_t e_cur;
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    mdl_cnt = 0;
  int    pend_len = 0;
  int    exp_len = 0;
  bit    flv_pend = 1'b0;
  int    sready_drain = 0;
  bit    rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: bytes a beat must produce, derived from keep/tlast rules.
  task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    int fin;
    fin = -1;
    for (int i = 0; i < KW; i++) if (k[i]) fin = i;
    if (fin < 0) begin
      if (l) exp_q.push_back('{d: d[7:0], l: 1'b1, u: u});
    end else begin
      for (int i = 0; i <= fin; i++) begin
`ifdef AXIS_UNPACK_SPARSE_KEEP_EN
        if (!k[i]) continue;
`endif
        exp_q.push_back('{d: d[i*8 +: 8], l: l && (i == fin), u: u});
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (flv_pend) exp_len = pend_len;
      check("frame_len_valid", frame_len_valid, flv_pend);
      check("frame_len", frame_len, exp_len);
      flv_pend = 1'b0;
      check("s_tready", s_if.tready, (exp_q.size() == 0) || (m_if.tready && exp_q.size() == 1));
      check("m_tvalid", m_if.tvalid, exp_q.size() > 0);
      if (m_if.tvalid && s_if.tready) sready_drain++;
      if (m_if.tvalid && exp_q.size() > 0) begin
        e_cur = exp_q[0];
        check("m_tdata", m_if.tdata, e_cur.d);
        check("m_tlast", m_if.tlast, e_cur.l);
        check("m_tuser", m_if.tuser, e_cur.u);
        if (m_if.tready) begin
          void'(exp_q.pop_front());
          log_q.push_back('{d: m_if.tdata, l: m_if.tlast, u: m_if.tuser[0]});
          log_cyc.push_back(cyc);
          mdl_cnt++;
          if (e_cur.l) begin
            pend_len = (mdl_cnt > 65535) ? 65535 : mdl_cnt;
            flv_pend = 1'b1;
            mdl_cnt  = 0;
          end
        end
      end
      if (s_if.tvalid && s_if.tready)
        push_beat(s_if.tdata, s_if.tkeep, s_if.tlast, s_if.tuser[0]);
    end
  end

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin
    @(posedge clk);
    while (cyc < 90000) @(posedge clk);
    $display("FAIL watchdog: actual=%0d cycles required=<90000", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  // Called and returns at posedge+1.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    int t;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tuser  = u;
    s_if.tvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (s_if.tready) break;
      t++;
      if (t > 1000) begin
        check("s_handshake_timeout", 64'(t), 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && !m_if.tvalid) && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 5000) check("idle_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    exp_q.delete();
    mdl_cnt  = 0;
    flv_pend = 1'b0;
    exp_len  = 0;
  endtask

  initial begin
    int base, gaps, ucnt, nb, t;
    logic [7:0] k;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tid    = '0;
    s_if.tdest  = '0;
    s_if.tuser  = '0;

    #1;
    check("rst_m_tvalid", m_if.tvalid, 1'b0);
    check("rst_s_tready", s_if.tready, 1'b1);
    check("rst_m_tdata", m_if.tdata, 8'h00);
    check("rst_frame_len", frame_len, 16'h0000);
    check("rst_frame_len_valid", frame_len_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single full beat
    base = log_q.size();
    send_beat(64'h0807060504030201, 8'hFF, 1'b1, 1'b0);
    wait_idle();
    check("t1_count", 64'(log_q.size() - base), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check("t1_byte", log_q[base+i].d, 64'(i + 1));
      check("t1_last", log_q[base+i].l, (i == 7));
    end
    check("t1_frame_len", frame_len, 16'd8);
    check("t1_tid", m_if.tid, 8'h00);

    // Three back-to-back beats
    base = log_q.size();
    sready_drain = 0;
    for (int b = 0; b < 3; b++)
      send_beat({$urandom, $urandom}, 8'hFF, (b == 2), 1'b0);
    wait_idle();
    check("t2_count", 64'(log_q.size() - base), 64'd24);
    gaps = 0;
    for (int i = base + 1; i < log_q.size(); i++)
      if (log_cyc[i] - log_cyc[i-1] != 1) gaps++;
    check("t2_gaps", 64'(gaps), 64'd0);
    check("t2_sready_cycles", 64'(sready_drain), 64'd3);
    check("t2_frame_len", frame_len, 16'd24);

    // Partial and sparse keep
    base = log_q.size();
    send_beat(64'h0000000000CCBBAA, 8'h07, 1'b1, 1'b0);
    wait_idle();
    check("t3_count", 64'(log_q.size() - base), 64'd3);
    check("t3_last_byte", log_q[log_q.size()-1].d, 8'hCC);
    check("t3_last_flag", log_q[log_q.size()-1].l, 1'b1);
    check("t3_frame_len", frame_len, 16'd3);
    base = log_q.size();
    send_beat(64'h8877665544332211, 8'h85, 1'b1, 1'b0);
    wait_idle();
`ifdef AXIS_UNPACK_SPARSE_KEEP_EN
    check("t3_sparse_count", 64'(log_q.size() - base), 64'd3);
    check("t3_sparse_b1", log_q[base+1].d, 8'h33);
    check("t3_sparse_len", frame_len, 16'd3);
`else
    check("t3_sparse_count", 64'(log_q.size() - base), 64'd8);
    check("t3_sparse_b1", log_q[base+1].d, 8'h22);
    check("t3_sparse_len", frame_len, 16'd8);
`endif

    // Random frames with random backpressure
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        case ($urandom_range(0, 3))
          0:       k = 8'hFF;
          1:       k = 8'hFF >> $urandom_range(0, 7);
          2:       k = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
          default: k = 8'($urandom);
        endcase
        send_beat({$urandom, $urandom}, k, (b == nb - 1), 1'($urandom));
      end
    end
    wait_idle();
    rand_ready = 1'b0;

    // tuser propagation and empty-keep beats
    base = log_q.size();
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b1);
    send_beat({$urandom, $urandom}, 8'hFF, 1'b1, 1'b1);
    wait_idle();
    ucnt = 0;
    for (int i = base; i < log_q.size(); i++) if (log_q[i].u) ucnt++;
    check("t5_tuser_bytes", 64'(ucnt), 64'd16);
    base = log_q.size();
    send_beat(64'h1122334455667788, 8'h00, 1'b0, 1'b0);
    wait_idle();
    check("t5_drop_count", 64'(log_q.size() - base), 64'd0);
    send_beat(64'h00000000000000AB, 8'h00, 1'b1, 1'b0);
    wait_idle();
    check("t5_zero_keep_count", 64'(log_q.size() - base), 64'd1);
    check("t5_zero_keep_byte", log_q[log_q.size()-1].d, 8'hAB);
    check("t5_zero_keep_last", log_q[log_q.size()-1].l, 1'b1);
    check("t5_zero_keep_len", frame_len, 16'd1);

    // Reset in the middle of a frame
    base = log_q.size();
    send_beat(64'h0807060504030201, 8'hFF, 1'b0, 1'b0);
    t = 0;
    while (log_q.size() < base + 3 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    do_reset();
    #1;
    check("t6_rst_tvalid", m_if.tvalid, 1'b0);
    check("t6_rst_tready", s_if.tready, 1'b1);
    check("t6_rst_len", frame_len, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(64'h000000000000BEEF, 8'h03, 1'b1, 1'b0);
    wait_idle();
    check("t6_post_rst_len", frame_len, 16'd2);

    // Oversized frame saturates the length
    for (int b = 0; b < 8750; b++)
      send_beat({$urandom, $urandom}, 8'hFF, (b == 8749), 1'b0);
    wait_idle();
    check("t6_sat_len", frame_len, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
